spongent_duplex_unrolled: RTL and testbench



---
 rtl/spongent_duplex_unrolled_if.sv | 24 ++
 rtl/spongent_duplex_unrolled.sv | 185 ++++++++++++++++++
 tb/tb_spongent_duplex_unrolled.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spongent_duplex_unrolled_if.sv
// Absorb/squeeze stream bundle of the SPONGENT duplex core.
// master = sequencer/message-buffer side, slave = the core.
interface spongent_duplex_unrolled_if #(
  parameter int RATE = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [RATE-1:0] in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [RATE-1:0] out_data;
  logic            out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/spongent_duplex_unrolled.sv
// SPONGENT sponge core: absorbs RATE-bit padded blocks, runs the permutation
// UNROLL rounds per clock, then squeezes OUT_BLOCKS digest blocks.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | one-cycle gap after reset, abort or finished digest
// S_ABSORB  | in_ready high, waiting for the next padded block
// S_PERMUTE | ROUNDS/UNROLL cycles of permutation, no handshakes
// S_SQUEEZE | out_valid high, presenting state[RATE-1:0]
module spongent_duplex_unrolled #(
  parameter int                    STATE_SIZE = 136,
  parameter int                    RATE       = 8,
  parameter int                    ROUNDS     = 70,
  parameter int                    UNROLL     = 1,
  parameter int unsigned           LFSR_POLY  = 8'b11000001,
  parameter int                    LFSR_SIZE  = $clog2(LFSR_POLY + 1) - 1,
  parameter logic [LFSR_SIZE-1:0]  LFSR_INIT  = 7'h7A,
  parameter int                    OUT_BLOCKS = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic abort,
  output logic busy,
  spongent_duplex_unrolled_if.slave bus
);

  localparam int CYCLES = ROUNDS / UNROLL;
  localparam int RC_W   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int CNT_W  = (OUT_BLOCKS > 1) ? $clog2(OUT_BLOCKS) : 1;
  localparam logic [RC_W-1:0]      RC_LAST  = RC_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(OUT_BLOCKS - 1);
  // Feedback taps: LFSR bit i feeds back when polynomial term x^(i+1) is set.
  localparam logic [LFSR_SIZE-1:0] TAPS     = LFSR_SIZE'(LFSR_POLY >> 1);

  if (ROUNDS % UNROLL != 0) begin : g_bad_unroll
    $error("ROUNDS must be a multiple of UNROLL");
  end
  if (STATE_SIZE % 4 != 0) begin : g_bad_state
    $error("STATE_SIZE must be a multiple of 4");
  end
  if (RATE >= STATE_SIZE) begin : g_bad_rate
    $error("RATE must be smaller than STATE_SIZE");
  end

  typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_PERMUTE, S_SQUEEZE} state_t;

  state_t                fsm, fsm_n;
  logic [STATE_SIZE-1:0] st, st_n, perm_st;
  logic [LFSR_SIZE-1:0]  lfsr, lfsr_n, perm_lfsr;
  logic [RC_W-1:0]       rc, rc_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  last_q, last_n;
  logic                  abort_q, abort_n;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hE;  4'h1: sbox = 4'hD;  4'h2: sbox = 4'hB;  4'h3: sbox = 4'h0;
      4'h4: sbox = 4'h2;  4'h5: sbox = 4'h1;  4'h6: sbox = 4'h4;  4'h7: sbox = 4'hF;
      4'h8: sbox = 4'h7;  4'h9: sbox = 4'hA;  4'hA: sbox = 4'h8;  4'hB: sbox = 4'h5;
      4'hC: sbox = 4'h9;  4'hD: sbox = 4'hC;  4'hE: sbox = 4'h3;  default: sbox = 4'h6;
    endcase
  endfunction

  // Round constant in both ends, nibble S-box layer, then bit permutation.
  function automatic logic [STATE_SIZE-1:0] spn_round(input logic [STATE_SIZE-1:0] s,
                                                      input logic [LFSR_SIZE-1:0]  l);
    logic [STATE_SIZE-1:0] x;
    logic [STATE_SIZE-1:0] y;
    x = s;
    for (int i = 0; i < LFSR_SIZE; i++) begin
      x[i]                ^= l[i];
      x[STATE_SIZE-1-i]   ^= l[i];
    end
    for (int n = 0; n < STATE_SIZE / 4; n++) begin
      x[4*n +: 4] = sbox(x[4*n +: 4]);
    end
    y = '0;
    for (int j = 0; j < STATE_SIZE - 1; j++) begin
      y[(j * (STATE_SIZE / 4)) % (STATE_SIZE - 1)] = x[j];
    end
    y[STATE_SIZE-1] = x[STATE_SIZE-1];
    return y;
  endfunction

  function automatic logic [LFSR_SIZE-1:0] lfsr_step(input logic [LFSR_SIZE-1:0] l);
    return {l[LFSR_SIZE-2:0], ^(l & TAPS)};
  endfunction

  // Permutation slice: UNROLL rounds with the LFSR advanced between them.
  always_comb begin
    perm_st   = st;
    perm_lfsr = lfsr;
    for (int u = 0; u < UNROLL; u++) begin
      perm_st   = spn_round(perm_st, perm_lfsr);
      perm_lfsr = lfsr_step(perm_lfsr);
    end
  end

  // Next-state and datapath update; abort overrides every transition.
  always_comb begin
    fsm_n   = fsm;
    st_n    = st;
    lfsr_n  = lfsr;
    rc_n    = rc;
    cnt_n   = cnt;
    last_n  = last_q;
    abort_n = 1'b0;
    case (fsm)
      S_IDLE: fsm_n = S_ABSORB;
      S_ABSORB: begin
        if (bus.in_valid) begin
          st_n[RATE-1:0] = st[RATE-1:0] ^ bus.in_data;
          last_n         = bus.in_last;
          lfsr_n         = LFSR_INIT;
          rc_n           = RC_LAST;
          fsm_n          = S_PERMUTE;
        end
      end
      S_PERMUTE: begin
        st_n   = perm_st;
        lfsr_n = perm_lfsr;
        if (rc == '0) begin
          fsm_n = last_q ? S_SQUEEZE : S_ABSORB;
        end else begin
          rc_n = rc - 1'b1;
        end
      end
      S_SQUEEZE: begin
        if (bus.out_ready) begin
          if (cnt == CNT_LAST) begin
            st_n   = '0;
            cnt_n  = '0;
            last_n = 1'b0;
            fsm_n  = S_IDLE;
          end else begin
            cnt_n  = cnt + 1'b1;
            lfsr_n = LFSR_INIT;
            rc_n   = RC_LAST;
            fsm_n  = S_PERMUTE;
          end
        end
      end
      default: fsm_n = S_IDLE;
    endcase
    if (abort) begin
      fsm_n   = S_IDLE;
      st_n    = '0;
      cnt_n   = '0;
      last_n  = 1'b0;
      lfsr_n  = LFSR_INIT;
      rc_n    = '0;
      abort_n = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm     <= S_IDLE;
      st      <= '0;
      lfsr    <= LFSR_INIT;
      rc      <= '0;
      cnt     <= '0;
      last_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      fsm     <= fsm_n;
      st      <= st_n;
      lfsr    <= lfsr_n;
      rc      <= rc_n;
      cnt     <= cnt_n;
      last_q  <= last_n;
      abort_q <= abort_n;
    end
  end

  // Outputs decode from registered state only, so in_ready never sees in_valid.
  assign bus.in_ready  = (fsm == S_ABSORB);
  assign bus.out_valid = (fsm == S_SQUEEZE);
  assign bus.out_data  = (fsm == S_SQUEEZE) ? st[RATE-1:0] : '0;
  assign bus.out_last  = (fsm == S_SQUEEZE) && (cnt == CNT_LAST);
  // The IDLE cycle after an abort still reports busy.
  assign busy = (fsm != S_IDLE) || (|st) || abort_q;

endmodule

// File: tb/tb_spongent_duplex_unrolled.sv
// Bench for spongent_duplex_unrolled: three instances (default, UNROLL=5,
// 88-bit state) with a queue-based scoreboard fed by a bit-level sponge model.
module tb_spongent_duplex_unrolled;
  localparam int NB = 3;
  localparam int B_P    [NB] = '{136, 136, 88};
  localparam int RND_P  [NB] = '{70, 70, 45};
  localparam int LSZ_P  [NB] = '{7, 7, 6};
  localparam int POLY_P [NB] = '{'hC1, 'hC1, 'h61};
  localparam int INIT_P [NB] = '{'h7A, 'h7A, 'h05};
  localparam int OB_P   [NB] = '{16, 16, 10};
  localparam int CYC_P  [NB] = '{70, 14, 45};
  localparam int SBOX_T [16] = '{'hE, 'hD, 'hB, 'h0, 'h2, 'h1, 'h4, 'hF,
                                 'h7, 'hA, 'h8, 'h5, 'h9, 'hC, 'h3, 'h6};

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       in_valid_a  [NB];
  logic       in_last_a   [NB];
  logic [7:0] in_data_a   [NB];
  logic       out_ready_a [NB];
  logic       abort_a     [NB];
  logic       in_ready_a  [NB];
  logic       out_valid_a [NB];
  logic       out_last_a  [NB];
  logic [7:0] out_data_a  [NB];
  logic       busy_a      [NB];

  exp_t       exp_q [NB][$];
  logic [7:0] cap   [NB][$];
  logic [7:0] mbuf  [8];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  spongent_duplex_unrolled_if #(.RATE(8)) bus0 ();
  spongent_duplex_unrolled_if #(.RATE(8)) bus1 ();
  spongent_duplex_unrolled_if #(.RATE(8)) bus2 ();

  assign bus0.in_valid  = in_valid_a[0];
  assign bus0.in_data   = in_data_a[0];
  assign bus0.in_last   = in_last_a[0];
  assign bus0.out_ready = out_ready_a[0];
  assign in_ready_a[0]  = bus0.in_ready;
  assign out_valid_a[0] = bus0.out_valid;
  assign out_data_a[0]  = bus0.out_data;
  assign out_last_a[0]  = bus0.out_last;

  assign bus1.in_valid  = in_valid_a[1];
  assign bus1.in_data   = in_data_a[1];
  assign bus1.in_last   = in_last_a[1];
  assign bus1.out_ready = out_ready_a[1];
  assign in_ready_a[1]  = bus1.in_ready;
  assign out_valid_a[1] = bus1.out_valid;
  assign out_data_a[1]  = bus1.out_data;
  assign out_last_a[1]  = bus1.out_last;

  assign bus2.in_valid  = in_valid_a[2];
  assign bus2.in_data   = in_data_a[2];
  assign bus2.in_last   = in_last_a[2];
  assign bus2.out_ready = out_ready_a[2];
  assign in_ready_a[2]  = bus2.in_ready;
  assign out_valid_a[2] = bus2.out_valid;
  assign out_data_a[2]  = bus2.out_data;
  assign out_last_a[2]  = bus2.out_last;

  spongent_duplex_unrolled u1 (
    .clk(clk), .reset_n(reset_n), .abort(abort_a[0]), .busy(busy_a[0]), .bus(bus0)
  );

  spongent_duplex_unrolled #(.UNROLL(5)) u5 (
    .clk(clk), .reset_n(reset_n), .abort(abort_a[1]), .busy(busy_a[1]), .bus(bus1)
  );

  spongent_duplex_unrolled #(
    .STATE_SIZE(88), .RATE(8), .ROUNDS(45), .UNROLL(1),
    .LFSR_POLY(7'b1100001), .LFSR_SIZE(6), .LFSR_INIT(6'h05), .OUT_BLOCKS(10)
  ) u88 (
    .clk(clk), .reset_n(reset_n), .abort(abort_a[2]), .busy(busy_a[2]), .bus(bus2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bit-level sponge model: round constant, S-box, pLayer, LFSR, straight from the algorithm.
  function automatic logic [135:0] mdl_perm(input logic [135:0] s_in, input int k);
    logic [135:0] s;
    logic [135:0] t;
    int b, l, v, fb;
    s = s_in;
    b = B_P[k];
    l = INIT_P[k];
    for (int rr = 0; rr < RND_P[k]; rr++) begin
      for (int i = 0; i < LSZ_P[k]; i++) begin
        if (((l >> i) & 1) == 1) begin
          s[i]     = ~s[i];
          s[b-1-i] = ~s[b-1-i];
        end
      end
      for (int n = 0; n < b / 4; n++) begin
        v = int'(s[4*n +: 4]);
        s[4*n +: 4] = 4'(SBOX_T[v]);
      end
      t = '0;
      for (int j = 0; j < b - 1; j++) t[(j * b / 4) % (b - 1)] = s[j];
      t[b-1] = s[b-1];
      s = t;
      fb = 0;
      for (int i = 0; i < LSZ_P[k]; i++) begin
        if (((POLY_P[k] >> (i + 1)) & 1) == 1) fb = fb ^ ((l >> i) & 1);
      end
      l = ((l << 1) | fb) & ((1 << LSZ_P[k]) - 1);
    end
    return s;
  endfunction

  // Pushes the model digest for mbuf[0..len-1], then streams the blocks in.
  task automatic send_msg(input int k, input int len);
    logic [135:0] s;
    int t;
    s = '0;
    for (int i = 0; i < len; i++) begin
      s[7:0] = s[7:0] ^ mbuf[i];
      s = mdl_perm(s, k);
    end
    for (int o = 0; o < OB_P[k]; o++) begin
      exp_q[k].push_back({s[7:0], 1'(o == OB_P[k] - 1)});
      if (o < OB_P[k] - 1) s = mdl_perm(s, k);
    end
    @(posedge clk); #1;
    for (int i = 0; i < len; i++) begin
      in_valid_a[k] = 1'b1;
      in_data_a[k]  = mbuf[i];
      in_last_a[k]  = (i == len - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready_a[k] && t < 500);
      if (!in_ready_a[k]) chk($sformatf("dut%0d accept_timeout", k), 0, 1);
      @(posedge clk); #1;
    end
    in_valid_a[k] = 1'b0;
    in_last_a[k]  = 1'b0;
  endtask

  task automatic wait_drain(input int k, input int budget);
    int t;
    t = 0;
    while (exp_q[k].size() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk($sformatf("dut%0d drain_remaining", k), exp_q[k].size(), 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic cmp_caps(input string nm, input logic [7:0] a[$], input logic [7:0] b[$]);
    chk({nm, " len"}, a.size(), b.size());
    for (int i = 0; i < a.size() && i < b.size(); i++) chk($sformatf("%s byte%0d", nm, i), a[i], b[i]);
  endtask

  task automatic abort_pulse(input int k);
    @(posedge clk); #1;
    abort_a[k]     = 1'b1;
    out_ready_a[k] = 1'b1;
    @(posedge clk); #1;
    abort_a[k] = 1'b0;
    exp_q[k].delete();
    @(negedge clk);
    chk($sformatf("dut%0d abort out_valid", k), out_valid_a[k], 0);
    chk($sformatf("dut%0d abort in_ready", k), in_ready_a[k], 0);
    chk($sformatf("dut%0d abort out_last", k), out_last_a[k], 0);
    chk($sformatf("dut%0d abort busy", k), busy_a[k], 1);
    chk($sformatf("dut%0d abort state_nonzero", k), |u1.st, 0);
  endtask

  // Scoreboard monitor: pops on every output handshake, also checks
  // block spacing, stall stability and ready/valid exclusivity.
  int         blk        [NB];
  int         acc_cyc    [NB];
  int         hs_cyc     [NB];
  logic       prev_ov    [NB];
  logic       prev_stall [NB];
  logic [7:0] prev_d     [NB];
  logic       prev_l     [NB];

  always @(negedge clk) begin
    exp_t e;
    int   lat;
    for (int k = 0; k < NB; k++) begin
      if (!reset_n || abort_a[k]) begin
        blk[k]        = 0;
        prev_ov[k]    = 1'b0;
        prev_stall[k] = 1'b0;
      end else begin
        if (in_ready_a[k] && out_valid_a[k]) chk($sformatf("dut%0d ready_valid_overlap", k), 1, 0);
        if (in_valid_a[k] && in_ready_a[k] && in_last_a[k]) acc_cyc[k] = cyc;
        if (out_valid_a[k] && !prev_ov[k]) begin
          lat = cyc - ((blk[k] == 0) ? acc_cyc[k] : hs_cyc[k]);
          chk($sformatf("dut%0d block%0d latency", k, blk[k]), lat, CYC_P[k] + 1);
        end
        if (prev_stall[k]) begin
          chk($sformatf("dut%0d stall valid", k), out_valid_a[k], 1);
          chk($sformatf("dut%0d stall data", k), out_data_a[k], prev_d[k]);
          chk($sformatf("dut%0d stall last", k), out_last_a[k], prev_l[k]);
        end
        if (out_valid_a[k] && out_ready_a[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("dut%0d unexpected_output", k), 1, 0);
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("dut%0d block%0d data", k, blk[k]), out_data_a[k], e.d);
            chk($sformatf("dut%0d block%0d last", k, blk[k]), out_last_a[k], e.l);
          end
          cap[k].push_back(out_data_a[k]);
          hs_cyc[k] = cyc;
          blk[k] = out_last_a[k] ? 0 : blk[k] + 1;
        end
        prev_ov[k]    = out_valid_a[k];
        prev_stall[k] = out_valid_a[k] && !out_ready_a[k];
        prev_d[k]     = out_data_a[k];
        prev_l[k]     = out_last_a[k];
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dig_ref[$];
    logic [7:0] dig3[$];
    int t;
    reset_n = 1'b0;
    for (int k = 0; k < NB; k++) begin
      in_valid_a[k]  = 1'b0;
      in_last_a[k]   = 1'b0;
      in_data_a[k]   = 8'h00;
      out_ready_a[k] = 1'b1;
      abort_a[k]     = 1'b0;
      blk[k]         = 0;
      acc_cyc[k]     = 0;
      hs_cyc[k]      = 0;
    end

    // Reset: all outputs low, then one IDLE cycle, then ABSORB.
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < NB; k++) begin
        chk($sformatf("dut%0d rst in_ready", k), in_ready_a[k], 0);
        chk($sformatf("dut%0d rst out_valid", k), out_valid_a[k], 0);
        chk($sformatf("dut%0d rst out_last", k), out_last_a[k], 0);
        chk($sformatf("dut%0d rst out_data", k), out_data_a[k], 0);
        chk($sformatf("dut%0d rst busy", k), busy_a[k], 0);
      end
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("dut%0d idle in_ready", k), in_ready_a[k], 0);
      chk($sformatf("dut%0d idle busy", k), busy_a[k], 0);
    end
    @(negedge clk);
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("dut%0d absorb in_ready", k), in_ready_a[k], 1);
      chk($sformatf("dut%0d absorb busy", k), busy_a[k], 1);
    end

    // Single padded block, default config.
    mbuf[0] = 8'h80;
    cap[0].delete();
    send_msg(0, 1);
    wait_drain(0, 3000);
    dig_ref = cap[0];
    chk("dut0 single digest length", dig_ref.size(), 16);

    // Three-block message on UNROLL=1 and UNROLL=5; digests must agree.
    mbuf[0] = 8'h53; mbuf[1] = 8'hA7; mbuf[2] = 8'h80;
    cap[0].delete();
    send_msg(0, 3);
    wait_drain(0, 3000);
    dig3 = cap[0];

    cap[1].delete();
    send_msg(1, 3);
    // Back-pressure: stall block 5 for 20 cycles.
    t = 0;
    while (exp_q[1].size() != 12 && t < 1000) begin
      @(posedge clk); #2;
      t++;
    end
    chk("dut1 bp reached block5", exp_q[1].size(), 12);
    out_ready_a[1] = 1'b0;
    t = 0;
    while (!out_valid_a[1] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("dut1 bp block5 valid", out_valid_a[1], 1);
    repeat (20) @(negedge clk);
    chk("dut1 bp nothing consumed", exp_q[1].size(), 12);
    @(posedge clk); #1;
    out_ready_a[1] = 1'b1;
    wait_drain(1, 1000);
    cmp_caps("unroll1_vs_unroll5", dig3, cap[1]);

    // Abort mid-PERMUTE, then the same message again.
    mbuf[0] = 8'h80;
    send_msg(0, 1);
    repeat (30) @(posedge clk);
    abort_pulse(0);
    cap[0].delete();
    send_msg(0, 1);
    wait_drain(0, 3000);
    cmp_caps("after_abort_permute", cap[0], dig_ref);

    // Abort mid-SQUEEZE while a handshake is offered.
    send_msg(0, 1);
    t = 0;
    while (exp_q[0].size() != 10 && t < 3000) begin
      @(posedge clk); #2;
      t++;
    end
    chk("dut0 squeeze reached block7", exp_q[0].size(), 10);
    out_ready_a[0] = 1'b0;
    t = 0;
    while (!out_valid_a[0] && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("dut0 squeeze block7 valid", out_valid_a[0], 1);
    abort_pulse(0);
    cap[0].delete();
    send_msg(0, 1);
    wait_drain(0, 3000);
    cmp_caps("after_abort_squeeze", cap[0], dig_ref);

    // Alternate 88-bit configuration: one- and two-block messages.
    mbuf[0] = 8'h80;
    send_msg(2, 1);
    wait_drain(2, 1000);
    mbuf[0] = 8'h3C; mbuf[1] = 8'h80;
    send_msg(2, 2);
    wait_drain(2, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
